// File: rtl/agu_issue_queue.sv
// rtl/agu_issue_queue.sv - in-order load/store issue queue with CDB operand wake-up
module agu_issue_queue #(
  parameter int XLEN            = 64,
  parameter int ROB_INDEX_WIDTH = 8,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            alloc_valid,
  output logic                            alloc_ready,
  input  logic [XLEN-1:0]                 alloc_1st_value,
  input  logic [ROB_INDEX_WIDTH-1:0]      alloc_1st_tag,
  input  logic                            alloc_1st_ready,
  input  logic [XLEN-1:0]                 alloc_2nd_value,
  input  logic [ROB_INDEX_WIDTH-1:0]      alloc_2nd_tag,
  input  logic                            alloc_2nd_ready,
  input  logic [XLEN-1:0]                 alloc_immediate,
  input  logic [ROB_INDEX_WIDTH-1:0]      alloc_ROB_index,
  input  logic                            cdb_valid,
  input  logic [ROB_INDEX_WIDTH-1:0]      cdb_ROB_index,
  input  logic [XLEN-1:0]                 cdb_value,
  output logic                            dispatch_valid,
  input  logic                            dispatch_ready,
  output logic [XLEN-1:0]                 dispatch_1st_reg,
  output logic [XLEN-1:0]                 dispatch_2nd_reg,
  output logic [XLEN-1:0]                 dispatch_address,
  output logic [ROB_INDEX_WIDTH-1:0]      dispatch_ROB_index,
  output logic [$clog2(QUEUE_DEPTH):0]    occupancy,
  input  logic                            flush
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic                       ent_valid    [QUEUE_DEPTH];
  logic                       ent_1st_rdy  [QUEUE_DEPTH];
  logic [ROB_INDEX_WIDTH-1:0] ent_1st_tag  [QUEUE_DEPTH];
  logic [XLEN-1:0]            ent_1st_val  [QUEUE_DEPTH];
  logic                       ent_2nd_rdy  [QUEUE_DEPTH];
  logic [ROB_INDEX_WIDTH-1:0] ent_2nd_tag  [QUEUE_DEPTH];
  logic [XLEN-1:0]            ent_2nd_val  [QUEUE_DEPTH];
  logic [XLEN-1:0]            ent_imm      [QUEUE_DEPTH];
  logic [ROB_INDEX_WIDTH-1:0] ent_rob      [QUEUE_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic full;
  logic head_valid;
  logic do_alloc;
  logic do_dispatch;
  logic byp_1st;
  logic byp_2nd;

  assign full        = (count == CW'(QUEUE_DEPTH));
  assign alloc_ready = reset & ~full;
  assign head_valid  = ent_valid[head];

  assign dispatch_valid = head_valid & ent_1st_rdy[head] & ent_2nd_rdy[head] & ~flush;
  assign dispatch_1st_reg   = head_valid ? ent_1st_val[head] : '0;
  assign dispatch_2nd_reg   = head_valid ? ent_2nd_val[head] : '0;
  assign dispatch_address   = head_valid ? ent_imm[head]     : '0;
  assign dispatch_ROB_index = head_valid ? ent_rob[head]     : '0;
  assign occupancy          = count;

  assign do_alloc    = alloc_valid & alloc_ready;
  assign do_dispatch = dispatch_valid & dispatch_ready;

  // A result broadcast in the allocation cycle would otherwise be missed forever.
  assign byp_1st = ~alloc_1st_ready & cdb_valid & (alloc_1st_tag == cdb_ROB_index);
  assign byp_2nd = ~alloc_2nd_ready & cdb_valid & (alloc_2nd_tag == cdb_ROB_index);

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
          if (ent_valid[i] && !ent_1st_rdy[i] && ent_1st_tag[i] == cdb_ROB_index) begin
            ent_1st_rdy[i] <= 1'b1;
            ent_1st_val[i] <= cdb_value;
          end
          if (ent_valid[i] && !ent_2nd_rdy[i] && ent_2nd_tag[i] == cdb_ROB_index) begin
            ent_2nd_rdy[i] <= 1'b1;
            ent_2nd_val[i] <= cdb_value;
          end
        end
      end
      if (do_dispatch) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      // Tail slot is never valid when allocating, so it cannot collide with the snoop.
      if (do_alloc) begin
        ent_valid[tail]   <= 1'b1;
        ent_1st_rdy[tail] <= alloc_1st_ready | byp_1st;
        ent_1st_tag[tail] <= alloc_1st_tag;
        ent_1st_val[tail] <= byp_1st ? cdb_value : alloc_1st_value;
        ent_2nd_rdy[tail] <= alloc_2nd_ready | byp_2nd;
        ent_2nd_tag[tail] <= alloc_2nd_tag;
        ent_2nd_val[tail] <= byp_2nd ? cdb_value : alloc_2nd_value;
        ent_imm[tail]     <= alloc_immediate;
        ent_rob[tail]     <= alloc_ROB_index;
        tail              <= tail + 1'b1;
      end
      count <= count + CW'(do_alloc) - CW'(do_dispatch);
    end
  end

endmodule

// File: tb/tb_agu_issue_queue.sv
// tb/tb_agu_issue_queue.sv - randomized and directed bench for agu_issue_queue
module tb_agu_issue_queue;

  logic        clock;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [63:0] alloc_1st_value;
  logic [7:0]  alloc_1st_tag;
  logic        alloc_1st_ready;
  logic [63:0] alloc_2nd_value;
  logic [7:0]  alloc_2nd_tag;
  logic        alloc_2nd_ready;
  logic [63:0] alloc_immediate;
  logic [7:0]  alloc_ROB_index;
  logic        cdb_valid;
  logic [7:0]  cdb_ROB_index;
  logic [63:0] cdb_value;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [63:0] dispatch_1st_reg;
  logic [63:0] dispatch_2nd_reg;
  logic [63:0] dispatch_address;
  logic [7:0]  dispatch_ROB_index;
  logic [2:0]  occupancy;
  logic        flush;

  agu_issue_queue #(.XLEN(64), .ROB_INDEX_WIDTH(8), .QUEUE_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_1st_value(alloc_1st_value), .alloc_1st_tag(alloc_1st_tag), .alloc_1st_ready(alloc_1st_ready),
    .alloc_2nd_value(alloc_2nd_value), .alloc_2nd_tag(alloc_2nd_tag), .alloc_2nd_ready(alloc_2nd_ready),
    .alloc_immediate(alloc_immediate), .alloc_ROB_index(alloc_ROB_index),
    .cdb_valid(cdb_valid), .cdb_ROB_index(cdb_ROB_index), .cdb_value(cdb_value),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_1st_reg(dispatch_1st_reg), .dispatch_2nd_reg(dispatch_2nd_reg),
    .dispatch_address(dispatch_address), .dispatch_ROB_index(dispatch_ROB_index),
    .occupancy(occupancy), .flush(flush)
  );

  typedef struct {
    logic        r1;
    logic [7:0]  t1;
    logic [63:0] v1;
    logic        r2;
    logic [7:0]  t2;
    logic [63:0] v2;
    logic [63:0] imm;
    logic [7:0]  rob;
  } ent_t;

  ent_t mq[$];
  int   tests = 0;
  int   fails = 0;
  bit   model_ok = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, applying the queue rules to the inputs sampled there.
  task automatic tick();
    ent_t e;
    bit   dv;
    bit   da;
    @(posedge clock);
    if (!reset || flush) begin
      mq.delete();
      if (!reset) model_ok = 1;
    end else begin
      dv = mq.size() > 0 && mq[0].r1 && mq[0].r2;
      da = alloc_valid && mq.size() < 4;
      if (cdb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].r1 && mq[i].t1 == cdb_ROB_index) begin mq[i].r1 = 1; mq[i].v1 = cdb_value; end
          if (!mq[i].r2 && mq[i].t2 == cdb_ROB_index) begin mq[i].r2 = 1; mq[i].v2 = cdb_value; end
        end
      end
      if (dv && dispatch_ready) void'(mq.pop_front());
      if (da) begin
        e.r1  = alloc_1st_ready || (cdb_valid && alloc_1st_tag == cdb_ROB_index);
        e.v1  = alloc_1st_ready ? alloc_1st_value : cdb_value;
        e.t1  = alloc_1st_tag;
        e.r2  = alloc_2nd_ready || (cdb_valid && alloc_2nd_tag == cdb_ROB_index);
        e.v2  = alloc_2nd_ready ? alloc_2nd_value : cdb_value;
        e.t2  = alloc_2nd_tag;
        e.imm = alloc_immediate;
        e.rob = alloc_ROB_index;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  always @(negedge clock) begin
    if (model_ok) begin
      chk("alloc_ready", {63'b0, alloc_ready}, {63'b0, reset && mq.size() < 4});
      chk("occupancy", {61'b0, occupancy}, 64'(mq.size()));
      chk("dispatch_valid", {63'b0, dispatch_valid},
          {63'b0, mq.size() > 0 && mq[0].r1 && mq[0].r2 && !flush});
      if (mq.size() == 0) begin
        chk("empty_1st", dispatch_1st_reg, 64'h0);
        chk("empty_2nd", dispatch_2nd_reg, 64'h0);
        chk("empty_addr", dispatch_address, 64'h0);
        chk("empty_rob", {56'b0, dispatch_ROB_index}, 64'h0);
      end else begin
        if (mq[0].r1) chk("head_1st", dispatch_1st_reg, mq[0].v1);
        if (mq[0].r2) chk("head_2nd", dispatch_2nd_reg, mq[0].v2);
        chk("head_addr", dispatch_address, mq[0].imm);
        chk("head_rob", {56'b0, dispatch_ROB_index}, {56'b0, mq[0].rob});
      end
    end
  end

  task automatic idle();
    alloc_valid = 0; alloc_1st_value = 0; alloc_1st_tag = 0; alloc_1st_ready = 1;
    alloc_2nd_value = 0; alloc_2nd_tag = 0; alloc_2nd_ready = 1;
    alloc_immediate = 0; alloc_ROB_index = 0;
    cdb_valid = 0; cdb_ROB_index = 0; cdb_value = 0;
    dispatch_ready = 0; flush = 0;
  endtask

  task automatic alloc(input logic [63:0] v1, input logic r1, input logic [7:0] t1,
                       input logic [63:0] v2, input logic r2, input logic [7:0] t2,
                       input logic [63:0] imm, input logic [7:0] rob);
    alloc_valid = 1;
    alloc_1st_value = v1; alloc_1st_ready = r1; alloc_1st_tag = t1;
    alloc_2nd_value = v2; alloc_2nd_ready = r2; alloc_2nd_tag = t2;
    alloc_immediate = imm; alloc_ROB_index = rob;
  endtask

  initial begin
    idle();
    reset = 0;
    repeat (3) tick();
    chk("rst_dv", {63'b0, dispatch_valid}, 64'h0);
    chk("rst_ar", {63'b0, alloc_ready}, 64'h0);
    chk("rst_occ", {61'b0, occupancy}, 64'h0);
    reset = 1;
    tick();
    chk("rel_ar", {63'b0, alloc_ready}, 64'h1);

    // ready allocation
    alloc(64'h1000, 1, 0, 64'h55, 1, 0, 64'h8, 8'd3);
    dispatch_ready = 1;
    tick();
    alloc_valid = 0;
    chk("rdy_dv", {63'b0, dispatch_valid}, 64'h1);
    chk("rdy_1st", dispatch_1st_reg, 64'h1000);
    chk("rdy_2nd", dispatch_2nd_reg, 64'h55);
    chk("rdy_addr", dispatch_address, 64'h8);
    chk("rdy_rob", {56'b0, dispatch_ROB_index}, 64'd3);
    tick();
    chk("rdy_occ0", {61'b0, occupancy}, 64'h0);

    // wake-up from CDB
    alloc(64'h0, 0, 8'd7, 64'h0, 1, 0, 64'h10, 8'd5);
    tick();
    alloc_valid = 0;
    chk("wk_wait", {63'b0, dispatch_valid}, 64'h0);
    tick();
    chk("wk_wait2", {63'b0, dispatch_valid}, 64'h0);
    cdb_valid = 1; cdb_ROB_index = 8'd7; cdb_value = 64'h2000;
    tick();
    cdb_valid = 0;
    chk("wk_dv", {63'b0, dispatch_valid}, 64'h1);
    chk("wk_1st", dispatch_1st_reg, 64'h2000);
    tick();

    // bypass in the allocation cycle
    alloc(64'h0, 0, 8'd7, 64'h0, 1, 0, 64'h18, 8'd6);
    cdb_valid = 1; cdb_ROB_index = 8'd7; cdb_value = 64'h3000;
    tick();
    alloc_valid = 0; cdb_valid = 0;
    chk("byp_dv", {63'b0, dispatch_valid}, 64'h1);
    chk("byp_1st", dispatch_1st_reg, 64'h3000);
    tick();

    // in-order issue
    alloc(64'h0, 0, 8'd9, 64'h0, 1, 0, 64'h0, 8'd1);
    tick();
    alloc(64'h77, 1, 0, 64'h0, 1, 0, 64'h0, 8'd2);
    tick();
    alloc_valid = 0;
    chk("ord_block", {63'b0, dispatch_valid}, 64'h0);
    chk("ord_occ", {61'b0, occupancy}, 64'd2);
    tick();
    chk("ord_block2", {63'b0, dispatch_valid}, 64'h0);
    cdb_valid = 1; cdb_ROB_index = 8'd9; cdb_value = 64'h40;
    tick();
    cdb_valid = 0;
    chk("ord_a_rob", {56'b0, dispatch_ROB_index}, 64'd1);
    chk("ord_a_1st", dispatch_1st_reg, 64'h40);
    tick();
    chk("ord_b_dv", {63'b0, dispatch_valid}, 64'h1);
    chk("ord_b_rob", {56'b0, dispatch_ROB_index}, 64'd2);
    tick();
    chk("ord_occ0", {61'b0, occupancy}, 64'h0);

    // full, overflow attempt, drain and refill across the wrap
    for (int r = 0; r < 2; r++) begin
      dispatch_ready = 0;
      for (int i = 0; i < 4; i++) begin
        alloc(64'(i), 1, 0, 64'h0, 1, 0, 64'h0, 8'(10 + 10 * r + i));
        tick();
      end
      chk("full_ar", {63'b0, alloc_ready}, 64'h0);
      chk("full_occ", {61'b0, occupancy}, 64'd4);
      alloc(64'h0, 1, 0, 64'h0, 1, 0, 64'h0, 8'd99);
      tick();
      alloc_valid = 0;
      chk("full_ign", {61'b0, occupancy}, 64'd4);
      dispatch_ready = 1;
      for (int i = 0; i < 4; i++) begin
        chk("drain_rob", {56'b0, dispatch_ROB_index}, 64'(10 + 10 * r + i));
        tick();
      end
      chk("drain_occ", {61'b0, occupancy}, 64'h0);
    end

    // flush with a concurrent allocation
    dispatch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      alloc(64'h1, 1, 0, 64'h0, 1, 0, 64'h0, 8'(40 + i));
      tick();
    end
    alloc(64'h1, 1, 0, 64'h0, 1, 0, 64'h0, 8'd50);
    flush = 1;
    #1;
    chk("fl_dv_during", {63'b0, dispatch_valid}, 64'h0);
    chk("fl_occ_before", {61'b0, occupancy}, 64'd3);
    tick();
    flush = 0; alloc_valid = 0;
    chk("fl_occ", {61'b0, occupancy}, 64'h0);
    chk("fl_dv", {63'b0, dispatch_valid}, 64'h0);
    tick();
    chk("fl_occ2", {61'b0, occupancy}, 64'h0);

    // reset mid-operation
    alloc(64'h1, 1, 0, 64'h0, 1, 0, 64'h0, 8'd60);
    tick();
    tick();
    alloc_valid = 0; reset = 0;
    tick();
    reset = 1;
    chk("mid_rst_occ", {61'b0, occupancy}, 64'h0);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      alloc_valid     = ($urandom_range(0, 9) < 6);
      alloc_1st_ready = $urandom_range(0, 1);
      alloc_1st_tag   = 8'($urandom_range(0, 7));
      alloc_1st_value = {$urandom, $urandom};
      alloc_2nd_ready = ($urandom_range(0, 2) != 0);
      alloc_2nd_tag   = 8'($urandom_range(0, 7));
      alloc_2nd_value = {$urandom, $urandom};
      alloc_immediate = {$urandom, $urandom};
      alloc_ROB_index = 8'($urandom);
      cdb_valid       = ($urandom_range(0, 9) < 4);
      cdb_ROB_index   = 8'($urandom_range(0, 7));
      cdb_value       = {$urandom, $urandom};
      dispatch_ready  = ($urandom_range(0, 9) < 7);
      flush           = ($urandom_range(0, 99) < 2);
      reset           = ($urandom_range(0, 99) != 0);
      tick();
    end

    idle();
    reset = 1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
